player_motion: RTL and testbench

Consumes the per-player heading produced by the game's direction controller and turns it into grid motion. Advances the player head one cell every MOVE_PERIOD clocks in the current direction. Before each step it checks the target cell against the playfield bounds and against the trail-occupancy store. It publishes the head position, a one-cycle step strobe for the trail writer, and a crash flag. The top level instantiates one per player.

---
 rtl/game_pkg.sv | 12 +
 rtl/player_motion_if.sv | 26 ++
 rtl/player_motion.sv | 162 ++++++++++++++++
 tb/tb_player_motion.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-wide types: per-player heading from the direction controller.
package game_pkg;

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    RIGHT = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    UP    = 3'd4
  } directions;

endpackage

// File: rtl/player_motion_if.sv
// Trail-occupancy query bus between a player_motion instance and the occupancy store.
interface player_motion_if #(
  parameter int unsigned XW = 7,
  parameter int unsigned YW = 6
) ();

  logic          occ_rd_req;
  logic [XW-1:0] occ_rd_x;
  logic [YW-1:0] occ_rd_y;
  logic          occ_rd_data;

  modport master (
    output occ_rd_req,
    output occ_rd_x,
    output occ_rd_y,
    input  occ_rd_data
  );

  modport slave (
    input  occ_rd_req,
    input  occ_rd_x,
    input  occ_rd_y,
    output occ_rd_data
  );

endinterface

// File: rtl/player_motion.sv
// Steps one player head across the grid every MOVE_PERIOD clocks, checking walls and
// trail occupancy before each step; publishes head, step strobe and crash flag.
module player_motion
  import game_pkg::*;
#(
  parameter int unsigned GRID_W      = 64,
  parameter int unsigned GRID_H      = 48,
  parameter int unsigned XW          = 7,
  parameter int unsigned YW          = 6,
  parameter int unsigned START_X     = 16,
  parameter int unsigned START_Y     = 24,
  parameter int unsigned MOVE_PERIOD = 2_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  directions              direction_i,
  input  logic                   restart_i,
  player_motion_if.master        occ_if,
  output logic          [XW-1:0] xpos_o,
  output logic          [YW-1:0] ypos_o,
  output logic                   step_valid_o,
  output logic                   crashed_o
);

  localparam int unsigned CW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

  // StQuery is the cycle the request is on the bus; the store answers in StCheck.
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StQuery = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StCrash = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [XW-1:0] x_q, x_d, qx_q, qx_d, nx;
  logic [YW-1:0] y_q, y_d, qy_q, qy_d, ny;
  logic          req_q, req_d;
  logic          step_q, step_d;
  logic          crash_q, crash_d;
  logic          moving, oob, terminal;

  assign terminal = (cnt_q == CW'(MOVE_PERIOD - 1));
  assign cnt_inc  = terminal ? '0 : cnt_q + CW'(1);

  // Bounds are judged on the current head, so the +/-1 below never wraps into the head.
  always_comb begin
    moving = 1'b1;
    oob    = 1'b0;
    nx     = x_q;
    ny     = y_q;
    case (direction_i)
      RIGHT: begin
        oob = (x_q == XW'(GRID_W - 1));
        nx  = x_q + XW'(1);
      end
      LEFT: begin
        oob = (x_q == '0);
        nx  = x_q - XW'(1);
      end
      DOWN: begin
        oob = (y_q == YW'(GRID_H - 1));
        ny  = y_q + YW'(1);
      end
      UP: begin
        oob = (y_q == '0);
        ny  = y_q - YW'(1);
      end
      default: moving = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    req_d   = 1'b0;
    step_d  = 1'b0;
    crash_d = crash_q;
    if (restart_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      x_d     = XW'(START_X);
      y_d     = YW'(START_Y);
      crash_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (moving) state_d = StRun;
        end
        StRun: begin
          cnt_d = cnt_inc;
          if (terminal && moving) begin
            if (oob) begin
              state_d = StCrash;
              crash_d = 1'b1;
            end else begin
              req_d   = 1'b1;
              qx_d    = nx;
              qy_d    = ny;
              state_d = StQuery;
            end
          end
        end
        StQuery: begin
          cnt_d   = cnt_inc;
          state_d = StCheck;
        end
        StCheck: begin
          cnt_d = cnt_inc;
          if (occ_if.occ_rd_data) begin
            state_d = StCrash;
            crash_d = 1'b1;
          end else begin
            x_d     = qx_q;
            y_d     = qy_q;
            step_d  = 1'b1;
            state_d = StRun;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= XW'(START_X);
      y_q     <= YW'(START_Y);
      qx_q    <= '0;
      qy_q    <= '0;
      req_q   <= 1'b0;
      step_q  <= 1'b0;
      crash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      req_q   <= req_d;
      step_q  <= step_d;
      crash_q <= crash_d;
    end
  end

  // The latched target doubles as the query address, which holds between requests.
  assign occ_if.occ_rd_req = req_q;
  assign occ_if.occ_rd_x   = qx_q;
  assign occ_if.occ_rd_y   = qy_q;
  assign xpos_o            = x_q;
  assign ypos_o            = y_q;
  assign step_valid_o      = step_q;
  assign crashed_o         = crash_q;

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion on an 8x8 grid: directed table, async reset, random run vs model.
module tb_player_motion;
  import game_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int SX = 3;
  localparam int SY = 3;
  localparam int MP = 4;

  logic       clk;
  logic       rst_n;
  directions  dir;
  logic       restart;
  logic [2:0] xpos, ypos;
  logic       step, crashed;
  bit         occ [0:W*H-1];
  int         checks, errors;

  player_motion_if #(.XW(3), .YW(3)) occ_if ();

  player_motion #(
    .GRID_W(W), .GRID_H(H), .XW(3), .YW(3),
    .START_X(SX), .START_Y(SY), .MOVE_PERIOD(MP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .direction_i (dir),
    .restart_i   (restart),
    .occ_if      (occ_if.master),
    .xpos_o      (xpos),
    .ypos_o      (ypos),
    .step_valid_o(step),
    .crashed_o   (crashed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Occupancy store: answers one cycle after the query.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_if.occ_rd_data <= 1'b0;
    else occ_if.occ_rd_data <= occ_if.occ_rd_req ?
                               occ[int'(occ_if.occ_rd_y) * W + int'(occ_if.occ_rd_x)] : 1'b0;
  end

  // Reference model: mode 0 idle, 1 running, 2 crashed; t counts clocks since run start;
  // a decided step resolves 2 clocks later (pend) with the outcome known from the map.
  int         m_mode, m_t, m_pend, n_mode, n_t, n_pend, tx, ty;
  bit         m_hit, n_hit, m_req, n_req, m_step, n_step, m_crash, n_crash;
  logic [2:0] m_x, m_y, m_qx, m_qy, n_x, n_y, n_qx, n_qy;

  always_comb begin
    n_mode = m_mode; n_t = m_t; n_pend = m_pend; n_hit = m_hit;
    n_x = m_x; n_y = m_y; n_qx = m_qx; n_qy = m_qy;
    n_req = 1'b0; n_step = 1'b0; n_crash = m_crash;
    tx = 0; ty = 0;
    if (restart) begin
      n_mode = 0; n_t = 0; n_pend = 0; n_x = 3'(SX); n_y = 3'(SY); n_crash = 1'b0;
    end else begin
      if (m_pend == 2) n_pend = 1;
      else if (m_pend == 1) begin
        n_pend = 0;
        if (m_hit) begin n_mode = 2; n_crash = 1'b1; end
        else begin n_x = m_qx; n_y = m_qy; n_step = 1'b1; end
      end
      if (m_mode == 0) begin
        if (dir != WAIT) begin n_mode = 1; n_t = 0; end
      end else if (m_mode == 1 && n_mode == 1) begin
        if (m_t == MP - 1 && dir != WAIT) begin
          tx = int'(m_x);
          ty = int'(m_y);
          case (dir)
            RIGHT:   tx = tx + 1;
            LEFT:    tx = tx - 1;
            DOWN:    ty = ty + 1;
            default: ty = ty - 1;
          endcase
          if (tx < 0 || tx >= W || ty < 0 || ty >= H) begin
            n_mode = 2; n_crash = 1'b1;
          end else begin
            n_req = 1'b1; n_qx = 3'(tx); n_qy = 3'(ty);
            n_hit = occ[ty * W + tx]; n_pend = 2;
          end
        end
        n_t = (m_t + 1) % MP;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_t <= 0; m_pend <= 0; m_hit <= 1'b0;
      m_x <= 3'(SX); m_y <= 3'(SY); m_qx <= '0; m_qy <= '0;
      m_req <= 1'b0; m_step <= 1'b0; m_crash <= 1'b0;
    end else begin
      m_mode <= n_mode; m_t <= n_t; m_pend <= n_pend; m_hit <= n_hit;
      m_x <= n_x; m_y <= n_y; m_qx <= n_qx; m_qy <= n_qy;
      m_req <= n_req; m_step <= n_step; m_crash <= n_crash;
    end
  end

  int steps_seen;

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    if (step) steps_seen++;
    checks++;
    if ({xpos, ypos, step, occ_if.occ_rd_req, crashed, occ_if.occ_rd_x, occ_if.occ_rd_y} !==
        {m_x, m_y, m_step, m_req, m_crash, m_qx, m_qy}) begin
      errors++;
      $display("FAIL model t=%0t: got x=%0d y=%0d step=%0b req=%0b crash=%0b q=(%0d,%0d) expected x=%0d y=%0d step=%0b req=%0b crash=%0b q=(%0d,%0d)",
               $time, xpos, ypos, step, occ_if.occ_rd_req, crashed, occ_if.occ_rd_x,
               occ_if.occ_rd_y, m_x, m_y, m_step, m_req, m_crash, m_qx, m_qy);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    directions d;
    bit        rs;
    int        cyc;
    int        ex;
    int        ey;
    bit        ec;
    int        esteps;
  } vec_t;

  vec_t vecs[9];

  initial begin
    checks = 0; errors = 0; steps_seen = 0;
    rst_n = 1'b0; dir = WAIT; restart = 1'b0;
    for (int i = 0; i < W * H; i++) occ[i] = 1'b0;
    occ[2 * W + 3] = 1'b1;

    vecs[0] = '{WAIT,  1'b0, 20, 3, 3, 1'b0, 0};  // idle holds at start
    vecs[1] = '{RIGHT, 1'b0, 24, 7, 3, 1'b1, 4};  // four steps, then wall at x=7
    vecs[2] = '{DOWN,  1'b0, 10, 7, 3, 1'b1, 0};  // crashed ignores direction
    vecs[3] = '{WAIT,  1'b1,  1, 3, 3, 1'b0, 0};
    vecs[4] = '{UP,    1'b0, 10, 3, 3, 1'b1, 0};  // (3,2) occupied
    vecs[5] = '{WAIT,  1'b1,  1, 3, 3, 1'b0, 0};
    vecs[6] = '{UP,    1'b0,  6, 3, 3, 1'b0, 0};  // stops in the check cycle
    vecs[7] = '{WAIT,  1'b1,  1, 3, 3, 1'b0, 0};  // restart beats occupied answer
    vecs[8] = '{WAIT,  1'b0,  4, 3, 3, 1'b0, 0};

    repeat (2) tick();
    chk("reset x", int'(xpos), SX);
    chk("reset y", int'(ypos), SY);
    chk("reset strobes/crash/q", int'({step, occ_if.occ_rd_req, crashed, occ_if.occ_rd_x,
                                      occ_if.occ_rd_y}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      dir = vecs[i].d;
      restart = vecs[i].rs;
      steps_seen = 0;
      for (int c = 0; c < vecs[i].cyc; c++) begin
        tick();
        restart = 1'b0;
      end
      chk($sformatf("row%0d x", i), int'(xpos), vecs[i].ex);
      chk($sformatf("row%0d y", i), int'(ypos), vecs[i].ey);
      chk($sformatf("row%0d crashed", i), int'(crashed), int'(vecs[i].ec));
      chk($sformatf("row%0d steps", i), steps_seen, vecs[i].esteps);
    end

    // Asynchronous reset between edges while running.
    dir = RIGHT;
    repeat (7) tick();
    chk("pre-reset x", int'(xpos), 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst x", int'(xpos), SX);
    chk("async rst y", int'(ypos), SY);
    chk("async rst strobes/crash", int'({step, occ_if.occ_rd_req, crashed}), 0);
    dir = WAIT;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post-rst idle x", int'(xpos), SX);
    dir = DOWN;
    repeat (7) tick();
    chk("post-rst first step y", int'(ypos), SY + 1);
    chk("post-rst first step x", int'(xpos), SX);

    // Random run against the model; the map only changes while restart is held.
    for (int blk = 0; blk < 6; blk++) begin
      restart = 1'b1;
      for (int i = 0; i < W * H; i++) occ[i] = ($urandom_range(0, 9) == 0);
      tick();
      restart = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 3) == 0) dir = directions'($urandom_range(0, 4));
        restart = ($urandom_range(0, 59) == 0);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
